// File: rtl/tagged_stream_arbiter.sv
// Round-robin arbiter that shares one registered data/id channel among NUM_REQ
// valid/ready requesters. Each grant lasts for a burst of up to MAX_BURST beats.
module tagged_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 32,
  parameter int MAX_BURST  = 4,
  localparam int SRC_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*ID_WIDTH-1:0]    req_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [SRC_W-1:0]               out_src,
  output logic                           busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                r_state;
  logic [SRC_W-1:0]      r_owner;
  logic [SRC_W-1:0]      r_last_owner;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic [SRC_W-1:0]      r_out_src;

  logic                  w_found;
  logic [SRC_W-1:0]      w_pick;
  logic [SRC_W-1:0]      w_idx;
  logic                  w_slot_free;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_next;

  // Round-robin pick: first valid requester after the previous owner, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = SRC_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = (r_state == S_GRANT) && req_valid[r_owner] && w_slot_free;
  assign w_cnt_next  = r_beat_cnt + CNT_W'(1);

  // Only the owner sees ready, and only while the output slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (r_state == S_GRANT) begin
      req_ready[r_owner] = w_slot_free;
    end else begin
      req_ready = '0;
    end
  end

  // Grant FSM together with the single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= SRC_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_out_src    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_accept) begin
            r_beat_cnt <= w_cnt_next;
          end
          // A dropped valid forfeits the rest of the burst, even while stalled.
          if (!req_valid[r_owner] || (w_accept && (w_cnt_next == CNT_W'(MAX_BURST)))) begin
            r_state      <= S_IDLE;
            r_last_owner <= r_owner;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
        r_out_id    <= req_id[int'(r_owner)*ID_WIDTH +: ID_WIDTH];
        r_out_src   <= r_owner;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_src   = r_out_src;
  assign busy      = (r_state == S_GRANT);

endmodule

// File: tb/tb_tagged_stream_arbiter.sv
// Directed bench for tagged_stream_arbiter: a MAX_BURST=4 instance for most
// scenarios and a MAX_BURST=1 instance for per-beat round-robin.
module tb_tagged_stream_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  req_data;
  logic [127:0] req_id;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [31:0]  out_id;
  logic [1:0]   out_src;
  logic         busy;

  logic [3:0]   req_valid_b;
  logic [3:0]   req_ready_b;
  logic         out_valid_b;
  logic [7:0]   out_data_b;
  logic [31:0]  out_id_b;
  logic [1:0]   out_src_b;
  logic         busy_b;

  int n_checks;
  int n_errors;

  tagged_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(32), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_id(req_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_src(out_src), .busy(busy)
  );

  tagged_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(32), .MAX_BURST(1)) u_dut_b1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_data(req_data), .req_id(req_id),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_id(out_id_b), .out_src(out_src_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [7:0] d, input logic [31:0] id);
    req_data[i*8 +: 8]  = d;
    req_id[i*32 +: 32]  = id;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = 4'b0000;
    req_valid_b = 4'b0000;
    out_ready   = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic       exp_valid;
    logic [1:0] exp_src;
    n_checks  = 0;
    n_errors  = 0;
    req_data  = 32'h0;
    req_id    = 128'h0;

    // Reset values, then all four requesters continuously valid.
    do_reset();
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_req_ready", 64'(req_ready), 64'h0);
    check_eq("rst_out_data", 64'(out_data), 64'h0);
    check_eq("rst_out_id", 64'(out_id), 64'h0);
    check_eq("rst_out_src", 64'(out_src), 64'h0);
    for (int i = 0; i < 4; i++) set_slot(i, 8'(8'h10 + i), 32'(32'h1000_0000 + i));
    req_valid = 4'b1111;
    step();
    check_eq("rr_first_ready", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 21; k++) begin
      step();
      exp_valid = (((k - 1) % 5) != 4);
      exp_src   = 2'(((k - 1) / 5) % 4);
      check_eq("rr_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        check_eq("rr_src", 64'(out_src), 64'(exp_src));
        check_eq("rr_data", 64'(out_data), 64'(8'h10 + exp_src));
      end
    end

    // Single beat from requester 2.
    do_reset();
    set_slot(2, 8'hA5, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    step();
    check_eq("sb_ready", 64'(req_ready), 64'h4);
    check_eq("sb_valid_n1", 64'(out_valid), 64'h0);
    check_eq("sb_busy", 64'(busy), 64'h1);
    step();
    req_valid = 4'b0000;
    check_eq("sb_valid_n2", 64'(out_valid), 64'h1);
    check_eq("sb_data", 64'(out_data), 64'hA5);
    check_eq("sb_id", 64'(out_id), 64'hDEAD_BEEF);
    check_eq("sb_src", 64'(out_src), 64'h2);
    step();
    check_eq("sb_valid_n3", 64'(out_valid), 64'h0);
    check_eq("sb_idle", 64'(busy), 64'h0);
    step();
    check_eq("sb_valid_n4", 64'(out_valid), 64'h0);

    // Backpressure during a burst from requester 1.
    do_reset();
    req_valid = 4'b0010;
    set_slot(1, 8'h01, 32'hB000_0001);
    step();
    check_eq("bp_ready", 64'(req_ready), 64'h2);
    step();
    check_eq("bp_beat1", 64'(out_data), 64'h01);
    set_slot(1, 8'h02, 32'hB000_0002);
    step();
    check_eq("bp_beat2", 64'(out_data), 64'h02);
    set_slot(1, 8'h03, 32'hB000_0003);
    out_ready = 1'b0;
    #1;
    check_eq("bp_stall_ready", 64'(req_ready), 64'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq("bp_hold_valid", 64'(out_valid), 64'h1);
      check_eq("bp_hold_data", 64'(out_data), 64'h02);
      check_eq("bp_hold_id", 64'(out_id), 64'hB000_0002);
      check_eq("bp_hold_src", 64'(out_src), 64'h1);
      check_eq("bp_hold_ready", 64'(req_ready), 64'h0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_resume_ready", 64'(req_ready), 64'h2);
    step();
    check_eq("bp_beat3", 64'(out_data), 64'h03);
    check_eq("bp_busy3", 64'(busy), 64'h1);
    set_slot(1, 8'h04, 32'hB000_0004);
    step();
    check_eq("bp_beat4", 64'(out_data), 64'h04);
    check_eq("bp_release", 64'(busy), 64'h0);
    req_valid = 4'b0000;
    step();
    check_eq("bp_drain", 64'(out_valid), 64'h0);

    // Requester 3 drops valid after two beats; requester 0 waits.
    do_reset();
    set_slot(3, 8'h31, 32'h3333_0000);
    set_slot(0, 8'h0A, 32'h0000_000A);
    req_valid = 4'b1000;
    step();
    check_eq("ed_ready3", 64'(req_ready), 64'h8);
    req_valid = 4'b1001;
    step();
    check_eq("ed_src_b1", 64'(out_src), 64'h3);
    step();
    check_eq("ed_valid_b2", 64'(out_valid), 64'h1);
    check_eq("ed_src_b2", 64'(out_src), 64'h3);
    req_valid = 4'b0001;
    step();
    check_eq("ed_no_b3", 64'(out_valid), 64'h0);
    check_eq("ed_released", 64'(busy), 64'h0);
    step();
    check_eq("ed_busy0", 64'(busy), 64'h1);
    check_eq("ed_ready0", 64'(req_ready), 64'h1);
    step();
    check_eq("ed_valid0", 64'(out_valid), 64'h1);
    check_eq("ed_src0", 64'(out_src), 64'h0);
    check_eq("ed_data0", 64'(out_data), 64'h0A);

    // MAX_BURST=1: requesters 0 and 1 alternate per beat.
    do_reset();
    req_valid_b = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_valid = ((k % 2) == 0);
      exp_src   = 2'(((k / 2) + 1) % 2);
      check_eq("b1_valid", 64'(out_valid_b), 64'(exp_valid));
      if (exp_valid) check_eq("b1_src", 64'(out_src_b), 64'(exp_src));
    end
    req_valid_b = 4'b0000;

    // Reset in the middle of a burst.
    do_reset();
    req_valid = 4'b0100;
    step();
    step();
    check_eq("mr_pre_valid", 64'(out_valid), 64'h1);
    check_eq("mr_pre_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    step();
    check_eq("mr_valid", 64'(out_valid), 64'h0);
    check_eq("mr_busy", 64'(busy), 64'h0);
    check_eq("mr_ready", 64'(req_ready), 64'h0);
    check_eq("mr_data", 64'(out_data), 64'h0);
    rst = 1'b0;
    req_valid = 4'b0101;
    step();
    check_eq("mr_next_owner", 64'(req_ready), 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tagged_stream_arbiter.md
Name: tagged_stream_arbiter

Overview:
- Round-robin arbiter sharing one tagged data channel (data + id) among NUM_REQ requesters.
- Each requester presents valid/ready with a DATA_WIDTH payload and an ID_WIDTH tag.
- The winner holds the channel for a burst of up to MAX_BURST beats.
- Output is a single registered valid/ready stage, feeding the downstream data/id consumer.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 8: payload width per beat.
- ID_WIDTH, 32: tag width per beat.
- MAX_BURST, 4: maximum consecutive beats per grant, ≥1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_id  input  NUM_REQ*ID_WIDTH  packed tags; requester i at [i*ID_WIDTH +: ID_WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  registered payload.
- out_id  output  ID_WIDTH  registered tag.
- out_src  output  $clog2(NUM_REQ)  index of the requester that produced the current output beat.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset: clock is clk; reset is rst, synchronous, active-high. On reset:
  - state=IDLE; owner=0; last_owner=NUM_REQ-1; beat_cnt=0.
  - out_valid=0, out_data=0, out_id=0, out_src=0, busy=0, req_ready=0.
  - A reset mid-burst discards any held output beat.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid bit is set, choose the first set index scanning from (last_owner+1) mod NUM_REQ upward with wrap.
  - Next cycle: owner=that index, beat_cnt=0, state=GRANT.
  - If no req_valid is set, stay in IDLE.
  - req_ready=0 throughout IDLE.
- GRANT:
  - req_ready[owner] = req_valid-independent, combinational: (!out_valid || out_ready). All other req_ready bits are 0.
  - A beat is accepted when req_valid[owner] && req_ready[owner].
  - On accept, the next cycle has: out_data/out_id = owner's slice, out_src=owner, out_valid=1, beat_cnt+1.
  - Release: state=IDLE and last_owner=owner next cycle when either:
    - (a) an accept brings beat_cnt to MAX_BURST, or
    - (b) req_valid[owner]==0 in any GRANT cycle, including stalled cycles.
  - Arbitration always passes through IDLE, giving a one-cycle bubble between grants.
- Output stage:
  - If out_valid && !out_ready: out_* hold stable and no accept occurs.
  - If out_valid && out_ready with no new accept, out_valid clears next cycle.
  - Simultaneous drain and accept: the new beat replaces the old one, so out_valid stays 1 (full throughput).
- Latency: req_valid rises in IDLE at cycle n → req_ready at n+1 → out_valid at n+2.
- Boundaries:
  - MAX_BURST=1 gives pure per-beat round-robin.
  - A requester dropping valid mid-burst forfeits the rest of its burst.
  - last_owner wraps NUM_REQ-1 → 0.
  - Data and id are sampled only on accept; values in non-accepted cycles are ignored.
- busy = (state==GRANT).

Test Plan:
- Reset priority:
  - Stimulus: after rst, req_valid=4'b1111 held, out_ready=1, MAX_BURST=4.
  - Required: owner order 0,1,2,3,0.
  - Required: each grant yields 4 beats with out_src constant, then 1 idle bubble.
- Single beat:
  - Stimulus: requester 2 only, data=8'hA5, id=32'hDEAD_BEEF, valid for one accepted beat then low.
  - Required: out_valid for exactly 1 cycle at n+2 with out_data=A5, out_id=DEADBEEF, out_src=2.
  - Required: return to IDLE.
- Backpressure:
  - Stimulus: requester 1 streaming; out_ready=0 for 3 cycles mid-burst.
  - Required: out_data/out_id/out_src stable.
  - Required: req_ready[1]=0 during the stall.
  - Required: no beat lost or duplicated; beat_cnt resumes and burst totals 4.
- Early drop:
  - Stimulus: requester 3 deasserts valid after 2 beats while requester 0 is waiting.
  - Required: release after 2 beats, then grant to 0 (wrap from 3).
- Burst limit:
  - Stimulus: MAX_BURST=1, requesters 0 and 1 continuously valid.
  - Required: out_src alternates 0,1,0,1.
- Reset mid-burst:
  - Stimulus: assert rst while out_valid=1 and in GRANT.
  - Required: next cycle out_valid=0, busy=0, req_ready=0.
  - Required: next arbitration starts from requester 0.
